// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction fetch path.
//   fetch_state_t      : fetch controller states (IDLE, WAIT, VALID, ERR)
//   NOP_INSTR          : canonical NOP (addi x0, x0, 0) loaded into the IR on reset
//   DEFAULT_INITIAL_PC : reset value of the program counter
//   PC_INCR            : sequential PC step in bytes
package riscv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        VALID = 2'd2,
        ERR   = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR          = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_INITIAL_PC = 32'h0040_0000;
    localparam logic [31:0] PC_INCR            = 32'd4;

endpackage

// File: rtl/pc_next_logic.sv
// Next-PC selection, shared with the datapath branch-target path.
// Ports:
//   pc            in  32  current program counter
//   pc_src        in   1  0: sequential (pc + 4), 1: branch (pc + branch_offset)
//   branch_offset in  32  sign-extended byte offset
//   next_pc       out 32  selected next PC, wraps modulo 2^32
module pc_next_logic
    import riscv_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        pc_src,
    input  logic [31:0] branch_offset,
    output logic [31:0] next_pc
);

    // Plain 32-bit adds: overflow wraps silently, no carry is reported.
    assign next_pc = pc_src ? (pc + branch_offset) : (pc + PC_INCR);

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues instruction-memory reads over a
// req/ready handshake with arbitrary wait states, and holds the fetched word in
// the instruction register while the control FSM decodes and executes it.
// Optional feature macro: FETCH_TIMEOUT_EN (bounded WAIT with timeout_err).
// Ports:
//   clk, rst          in      clock; synchronous active-high reset
//   fetch_start       in   1  fetch request from the control FSM
//   loadPC            in   1  commit PC update
//   PCSrc             in   1  0: PC+4, 1: PC+branch_offset
//   branch_offset     in  32  sign-extended byte offset
//   imem_req          out  1  read request (high exactly while in WAIT)
//   imem_addr         out 32  read address, stable while imem_req is high
//   imem_ready        in   1  imem_rdata is valid this cycle
//   imem_rdata        in  32  instruction word
//   PC                out 32  program counter
//   instr             out 32  instruction register
//   instr_valid       out  1  instr holds the word fetched from PC
//   fetch_busy        out  1  high while waiting on memory
//   misalign_err      out  1  sticky: fetch address not word aligned
//   timeout_err       out  1  sticky: memory did not answer in time
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] INITIAL_PC     = DEFAULT_INITIAL_PC,
    parameter int unsigned TIMEOUT_CYCLES = 16
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_start,
    input  logic        loadPC,
    input  logic        PCSrc,
    input  logic [31:0] branch_offset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        fetch_busy,
    output logic        misalign_err,
    output logic        timeout_err
);

    fetch_state_t state, state_n;
    logic [31:0]  next_pc, fetch_addr;
    logic [31:0]  pc_n, instr_n, addr_n;
    logic         misalign_n;
    logic         timeout_hit;

    pc_next_logic u_pc_next (
        .pc            (PC),
        .pc_src        (PCSrc),
        .branch_offset (branch_offset),
        .next_pc       (next_pc)
    );

    // A fetch issued together with loadPC targets the updated PC.
    assign fetch_addr = loadPC ? next_pc : PC;

    // Handshake outputs decode straight from the state flop, so they are
    // glitch-free registered signals and drop the cycle after leaving WAIT.
    assign imem_req    = (state == WAIT);
    assign fetch_busy  = (state == WAIT);
    assign instr_valid = (state == VALID);

`ifdef FETCH_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] wait_cnt;

    // Held at zero outside WAIT, so it is already clear on every WAIT entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state != WAIT)
                wait_cnt <= '0;
            else if (!imem_ready)
                wait_cnt <= wait_cnt + 8'd1;
            if (timeout_hit)
                timeout_err <= 1'b1;
        end
    end

    // A ready arriving on the last allowed cycle still completes normally.
    assign timeout_hit = (state == WAIT) && !imem_ready && (wait_cnt == TIMEOUT_LAST);
`else
    logic unused_timeout;

    assign timeout_hit    = 1'b0;
    assign timeout_err    = 1'b0;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            PC           <= INITIAL_PC;
            instr        <= NOP_INSTR;
            imem_addr    <= '0;
            misalign_err <= 1'b0;
        end else begin
            state        <= state_n;
            PC           <= pc_n;
            instr        <= instr_n;
            imem_addr    <= addr_n;
            misalign_err <= misalign_n;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a hold default first, so no
        // path through the case statement can infer a latch.
        state_n    = state;
        pc_n       = PC;
        instr_n    = instr;
        addr_n     = imem_addr;
        misalign_n = misalign_err;

        case (state)
            IDLE: begin
                if (loadPC)
                    pc_n = next_pc;
                if (fetch_start) begin
                    if (fetch_addr[1:0] != 2'b00) begin
                        misalign_n = 1'b1;
                        state_n    = ERR;
                    end else begin
                        addr_n  = fetch_addr;
                        state_n = WAIT;
                    end
                end
            end
            WAIT: begin
                // fetch_start and loadPC are deliberately ignored here.
                if (imem_ready) begin
                    instr_n = imem_rdata;
                    state_n = VALID;
                end else if (timeout_hit) begin
                    state_n = ERR;
                end
            end
            VALID: begin
                // loadPC wins; a simultaneous fetch_start is dropped. A plain
                // re-fetch skips the alignment check: PC was checked already.
                if (loadPC) begin
                    pc_n    = next_pc;
                    state_n = IDLE;
                end else if (fetch_start) begin
                    addr_n  = PC;
                    state_n = WAIT;
                end
            end
            ERR: begin
                state_n = ERR;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Upstream neighbour of the multicycle control FSM; owns the program counter.
- Issues instruction-memory reads over a req/ready handshake that tolerates wait states.
- Latches the returned word into an instruction register and holds it stable for the decode/execute/writeback cycles.
- Applies sequential (PC+4) or branch (PC+offset) PC update when the control FSM asserts loadPC.

Parameters:
- INITIAL_PC, 32'h00400000, PC value after reset
- TIMEOUT_CYCLES, 16, max WAIT cycles before timeout error (used only with FETCH_TIMEOUT_EN)

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- fetch_start  input  1  one-cycle request from control FSM (IF state) to fetch at current PC
- loadPC  input  1  commit PC update (WB state)
- PCSrc  input  1  0: PC+4, 1: PC+branch_offset
- branch_offset  input  32  sign-extended byte offset from datapath
- imem_req  output  1  read request to instruction memory
- imem_addr  output  32  read address, stable while imem_req=1
- imem_ready  input  1  memory returns imem_rdata this cycle
- imem_rdata  input  32  instruction word
- PC  output  32  current program counter
- instr  output  32  instruction register
- instr_valid  output  1  instr holds word fetched from PC
- fetch_busy  output  1  high in WAIT
- misalign_err  output  1  sticky, PC[1:0]!=0 at fetch
- timeout_err  output  1  sticky, memory timeout (tied 0 without feature)

Behaviour:
- Reset (rst=1 at clk edge): PC=INITIAL_PC, instr=32'h00000013 (NOP), instr_valid=0, imem_req=0, imem_addr=0, fetch_busy=0, misalign_err=0, timeout_err=0, state=IDLE. Reset is honoured in every state, including mid-WAIT; an outstanding request is abandoned (imem_req=0 next cycle).
- States: IDLE, WAIT, VALID, ERR.
- next_pc = PCSrc ? PC+branch_offset : PC+4, modulo 2^32 (wrap, no flag).
- IDLE: imem_req=0. On loadPC, PC<=next_pc. On fetch_start, fetch address = (loadPC ? next_pc : PC). If address[1:0]!=0, go ERR and set misalign_err. Otherwise imem_addr<=address, imem_req<=1, go WAIT.
- WAIT: imem_req, imem_addr held constant. When imem_ready=1: instr<=imem_rdata, instr_valid<=1, imem_req<=0, go VALID. fetch_start and loadPC are ignored in WAIT; PC is unchanged.
- VALID: instr, instr_valid held. On loadPC: PC<=next_pc, instr_valid<=0, go IDLE. loadPC has priority over a simultaneous fetch_start, which is dropped. fetch_start alone re-fetches the current PC: instr_valid<=0, go WAIT. Alignment is not rechecked because PC was already checked.
- ERR: imem_req=0, instr_valid=0, error flags held. Only rst exits.
- Latency: fetch_start in cycle N gives imem_req=1 in N+1. Zero-wait memory (ready in N+1) gives instr_valid=1 in N+2. Each memory wait state adds one cycle.
- fetch_busy = (state==WAIT), registered.

Optional Feature:
- Macro FETCH_TIMEOUT_EN.
- Defined: 8-bit wait counter cleared on entry to WAIT and incremented each WAIT cycle without imem_ready. When it reaches TIMEOUT_CYCLES-1 with imem_ready=0, the next edge sets imem_req=0, timeout_err=1 and goes to ERR. imem_ready on that same cycle wins: normal completion, no error.
- Undefined: no counter; WAIT lasts indefinitely; timeout_err is constant 0.

Decomposition:
- Shared package riscv_pkg: fetch state enum (IDLE/WAIT/VALID/ERR), NOP_INSTR=32'h00000013, default INITIAL_PC constant, PC_INCR=4.
- One combinational sub-module pc_next_logic (PC, PCSrc, branch_offset -> next_pc), reused by the datapath branch-target path.

Test Plan:
- Reset, then fetch_start with imem_ready tied 1, imem_rdata=32'h00500093 -> imem_req=1 at N+1 with imem_addr=32'h00400000; instr=32'h00500093 and instr_valid=1 at N+2.
- 3 wait states -> imem_req and imem_addr stable for 4 cycles; instr_valid rises the cycle after ready; a fetch_start pulse during WAIT has no effect.
- VALID, loadPC with PCSrc=0 -> PC=32'h00400004, instr_valid=0; loadPC with PCSrc=1, branch_offset=32'hFFFFFFF8 from PC=32'h00400010 -> PC=32'h00400008.
- PC=32'hFFFFFFFC, loadPC with PCSrc=0 -> PC=32'h00000000 (wrap). Branch_offset=2, then fetch_start -> misalign_err=1, imem_req stays 0, ERR held until rst.
- rst asserted during WAIT -> next cycle imem_req=0, PC=32'h00400000, instr=NOP, instr_valid=0.
- FETCH_TIMEOUT_EN with TIMEOUT_CYCLES=16, imem_ready held 0 -> timeout_err=1 and imem_req=0 after 16 WAIT cycles. Ready on the 16th cycle -> normal completion, timeout_err=0.
